// File: rtl/jtag_pkg.sv
// Shared TAP definitions for the JTAG state tracker: IEEE 1149.1 state codes
// and the next-state function used by both the RTL and its verification model.
package jtag_pkg;

    localparam int FILTER_CNT_W = 8;

    typedef enum logic [3:0] {
        TAP_EX2DR = 4'h0,
        TAP_EX1DR = 4'h1,
        TAP_SHDR  = 4'h2,
        TAP_PDR   = 4'h3,
        TAP_SELIR = 4'h4,
        TAP_UPDR  = 4'h5,
        TAP_CAPDR = 4'h6,
        TAP_SELDR = 4'h7,
        TAP_EX2IR = 4'h8,
        TAP_EX1IR = 4'h9,
        TAP_SHIR  = 4'hA,
        TAP_PIR   = 4'hB,
        TAP_RTI   = 4'hC,
        TAP_UPIR  = 4'hD,
        TAP_CAPIR = 4'hE,
        TAP_TLR   = 4'hF
    } tap_state_t;

    function automatic tap_state_t next_tap(input tap_state_t state, input logic tms);
        case (state)
            TAP_TLR:   return tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   return tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: return tms ? TAP_SELIR : TAP_CAPDR;
            TAP_SELIR: return tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPDR: return tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  return tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: return tms ? TAP_UPDR  : TAP_PDR;
            TAP_PDR:   return tms ? TAP_EX2DR : TAP_PDR;
            TAP_EX2DR: return tms ? TAP_UPDR  : TAP_SHDR;
            TAP_UPDR:  return tms ? TAP_SELDR : TAP_RTI;
            TAP_CAPIR: return tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  return tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: return tms ? TAP_UPIR  : TAP_PIR;
            TAP_PIR:   return tms ? TAP_EX2IR : TAP_PIR;
            TAP_EX2IR: return tms ? TAP_UPIR  : TAP_SHIR;
            TAP_UPIR:  return tms ? TAP_SELDR : TAP_RTI;
            default:   return TAP_TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_sync_filter.sv
// One asynchronous pin: 2-FF synchronizer followed by a registered filtered value.
// With JTAG_GLITCH_FILTER_EN defined, the output only follows FILTER_LEN consecutive equal samples.
module jtag_sync_filter
    import jtag_pkg::*;
#(
    parameter logic RESET_VAL  = 1'b0,
    parameter int   FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic sync1;
    logic sync2;

    if (FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_bad_filter_len
        $error("jtag_sync_filter: FILTER_LEN must be within 2..255");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

`ifdef JTAG_GLITCH_FILTER_EN
    // Counts consecutive samples that disagree with the current output.
    logic [FILTER_CNT_W-1:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout    <= RESET_VAL;
            run_cnt <= '0;
        end else if (sync2 == dout) begin
            run_cnt <= '0;
        end else if (run_cnt == FILTER_CNT_W'(FILTER_LEN - 1)) begin
            dout    <= sync2;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= RESET_VAL;
        end else begin
            dout <= sync2;
        end
    end
`endif

endmodule

// File: rtl/jtag_tap_tracker.sv
// Shadow IEEE 1149.1 TAP controller driven by sampled TCK/TMS pins, emitting one
// valid/ready event per state change. Optional glitch filter: JTAG_GLITCH_FILTER_EN.
module jtag_tap_tracker
    import jtag_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       jtag_clk,
    input  logic       jtag_tms,
    output logic [3:0] tap_state,
    output logic       test_logic_reset,
    output logic       tck_rise,
    output logic       evt_valid,
    output logic [3:0] evt_state,
    input  logic       evt_ready,
    output logic       evt_overrun
);

    logic       tck_f;
    logic       tms_f;
    logic       tck_prev;
    logic       rise_d;
    logic       change_d;
    logic       evt_valid_d;
    logic [3:0] evt_state_d;
    logic       overrun_d;
    tap_state_t cur_state;
    tap_state_t nxt_state;

    jtag_sync_filter #(.RESET_VAL(1'b0), .FILTER_LEN(FILTER_LEN)) u_tck_filter (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .din   (jtag_clk),
        .dout  (tck_f)
    );

    jtag_sync_filter #(.RESET_VAL(1'b1), .FILTER_LEN(FILTER_LEN)) u_tms_filter (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .din   (jtag_tms),
        .dout  (tms_f)
    );

    assign tap_state = cur_state;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tck_prev         <= 1'b0;
            cur_state        <= TAP_TLR;
            test_logic_reset <= 1'b1;
            tck_rise         <= 1'b0;
            evt_valid        <= 1'b0;
            evt_state        <= TAP_TLR;
            evt_overrun      <= 1'b0;
        end else begin
            tck_prev         <= tck_f;
            cur_state        <= nxt_state;
            test_logic_reset <= (nxt_state == TAP_TLR);
            tck_rise         <= rise_d;
            evt_valid        <= evt_valid_d;
            evt_state        <= evt_state_d;
            evt_overrun      <= overrun_d;
        end
    end

    // A new event takes priority over an accept; it only counts as an overrun
    // when the pending one was not being taken in the same cycle.
    always_comb begin
        rise_d      = tck_f & ~tck_prev;
        nxt_state   = cur_state;
        evt_valid_d = evt_valid;
        evt_state_d = evt_state;
        overrun_d   = evt_overrun;
        if (rise_d) begin
            nxt_state = next_tap(cur_state, tms_f);
        end
        change_d = rise_d && (nxt_state != cur_state);
        if (change_d) begin
            evt_valid_d = 1'b1;
            evt_state_d = nxt_state;
            if (evt_valid && !evt_ready) begin
                overrun_d = 1'b1;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_tracker.sv
// Directed self-checking bench for jtag_tap_tracker; filter-specific checks
// are compiled only when JTAG_GLITCH_FILTER_EN is defined.
`timescale 1ns/1ps
module tb_jtag_tap_tracker;

    localparam int FILTER_LEN = 4;
`ifdef JTAG_GLITCH_FILTER_EN
    localparam int LAT = 3 + FILTER_LEN - 1;
`else
    localparam int LAT = 3;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       jtag_clk = 1'b0;
    logic       jtag_tms = 1'b1;
    logic       evt_ready = 1'b1;
    logic [3:0] tap_state;
    logic       test_logic_reset;
    logic       tck_rise;
    logic       evt_valid;
    logic [3:0] evt_state;
    logic       evt_overrun;

    int checks = 0;
    int failures = 0;

    int         p_rises;
    int         p_edge;
    logic       p_valid;
    logic [3:0] p_state;

    jtag_tap_tracker #(.FILTER_LEN(FILTER_LEN)) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .jtag_clk         (jtag_clk),
        .jtag_tms         (jtag_tms),
        .tap_state        (tap_state),
        .test_logic_reset (test_logic_reset),
        .tck_rise         (tck_rise),
        .evt_valid        (evt_valid),
        .evt_state        (evt_state),
        .evt_ready        (evt_ready),
        .evt_overrun      (evt_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        jtag_clk  = 1'b0;
        jtag_tms  = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    // One TCK pulse: TMS settles first, TCK high for 10 samples, low for 14.
    // ready_edge >= 0 drives evt_ready high only at that sampling edge.
    task automatic tck_pulse(input logic tms_val, input int ready_edge,
                             output int rises, output int first_edge,
                             output logic v_at, output logic [3:0] s_at);
        @(negedge sys_clk);
        jtag_tms = tms_val;
        repeat (8) @(negedge sys_clk);
        jtag_clk   = 1'b1;
        rises      = 0;
        first_edge = -1;
        v_at       = 1'b0;
        s_at       = 4'h0;
        for (int k = 0; k < 24; k++) begin
            if (ready_edge >= 0) evt_ready = (k == ready_edge);
            if (k == 10) jtag_clk = 1'b0;
            @(posedge sys_clk);
            #1;
            if (tck_rise === 1'b1) begin
                rises++;
                if (first_edge < 0) begin
                    first_edge = k;
                    v_at       = evt_valid;
                    s_at       = evt_state;
                end
            end
            @(negedge sys_clk);
        end
        if (ready_edge >= 0) evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        evt_ready = 1'b1;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (tap_state !== 4'hF) begin failures++; $display("[TB] FAIL reset_tap_state got=%h exp=%h", tap_state, 4'hF); end
        checks++; if (test_logic_reset !== 1'b1) begin failures++; $display("[TB] FAIL reset_tlr got=%b exp=1", test_logic_reset); end
        checks++; if (evt_valid !== 1'b0 || evt_overrun !== 1'b0 || tck_rise !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags got v=%b o=%b r=%b exp 0/0/0", evt_valid, evt_overrun, tck_rise); end
        checks++; if (evt_state !== 4'hF) begin failures++; $display("[TB] FAIL reset_evt_state got=%h exp=%h", evt_state, 4'hF); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1;
        checks++; if (tap_state !== 4'hF || test_logic_reset !== 1'b1) begin failures++; $display("[TB] FAIL hold_after_reset got state=%h tlr=%b exp F/1", tap_state, test_logic_reset); end
        checks++; if (evt_valid !== 1'b0 || evt_overrun !== 1'b0) begin failures++; $display("[TB] FAIL hold_flags got v=%b o=%b exp 0/0", evt_valid, evt_overrun); end
    endtask

    task automatic test_walk_to_shdr();
        logic       tms_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp_st  [4] = '{4'hC, 4'h7, 4'h6, 4'h2};
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tck_pulse(tms_seq[i], -1, p_rises, p_edge, p_valid, p_state);
            checks++; if (p_rises !== 1 || p_edge !== LAT) begin failures++; $display("[TB] FAIL walk_rise[%0d] got rises=%0d edge=%0d exp 1 at %0d", i, p_rises, p_edge, LAT); end
            checks++; if (p_valid !== 1'b1 || p_state !== exp_st[i]) begin failures++; $display("[TB] FAIL walk_event[%0d] got v=%b s=%h exp 1/%h", i, p_valid, p_state, exp_st[i]); end
            checks++; if (tap_state !== exp_st[i] || evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL walk_state[%0d] got state=%h v=%b exp %h/0", i, tap_state, evt_valid, exp_st[i]); end
        end
        tck_pulse(1'b0, -1, p_rises, p_edge, p_valid, p_state);
        checks++; if (p_rises !== 1 || p_valid !== 1'b0) begin failures++; $display("[TB] FAIL shdr_selfloop got rises=%0d v=%b exp 1/0", p_rises, p_valid); end
        checks++; if (tap_state !== 4'h2 || test_logic_reset !== 1'b0) begin failures++; $display("[TB] FAIL shdr_hold got state=%h tlr=%b exp 2/0", tap_state, test_logic_reset); end
    endtask

    task automatic test_ir_to_tlr();
        logic       tms_seq [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp_st  [11] = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hD, 4'h7, 4'h4, 4'hF};
        evt_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tck_pulse(tms_seq[i], -1, p_rises, p_edge, p_valid, p_state);
            checks++; if (tap_state !== exp_st[i] || p_state !== exp_st[i]) begin failures++; $display("[TB] FAIL ir_walk[%0d] got state=%h evt=%h exp %h", i, tap_state, p_state, exp_st[i]); end
        end
        checks++; if (test_logic_reset !== 1'b1) begin failures++; $display("[TB] FAIL ir_tlr got=%b exp=1", test_logic_reset); end
    endtask

    task automatic test_overrun();
        do_reset();
        tck_pulse(1'b0, 99, p_rises, p_edge, p_valid, p_state);
        checks++; if (p_valid !== 1'b1 || p_state !== 4'hC || evt_overrun !== 1'b0) begin failures++; $display("[TB] FAIL ovr_first got v=%b s=%h o=%b exp 1/C/0", p_valid, p_state, evt_overrun); end
        tck_pulse(1'b1, 99, p_rises, p_edge, p_valid, p_state);
        checks++; if (evt_valid !== 1'b1 || evt_state !== 4'h7 || evt_overrun !== 1'b1) begin failures++; $display("[TB] FAIL ovr_second got v=%b s=%h o=%b exp 1/7/1", evt_valid, evt_state, evt_overrun); end
        @(negedge sys_clk);
        evt_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        checks++; if (evt_valid !== 1'b0 || evt_overrun !== 1'b1) begin failures++; $display("[TB] FAIL ovr_accept got v=%b o=%b exp 0/1", evt_valid, evt_overrun); end
        @(negedge sys_clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        tck_pulse(1'b0, 99, p_rises, p_edge, p_valid, p_state);
        tck_pulse(1'b1, LAT, p_rises, p_edge, p_valid, p_state);
        checks++; if (p_valid !== 1'b1 || p_state !== 4'h7) begin failures++; $display("[TB] FAIL b2b_event got v=%b s=%h exp 1/7", p_valid, p_state); end
        checks++; if (evt_valid !== 1'b1 || evt_state !== 4'h7 || evt_overrun !== 1'b0) begin failures++; $display("[TB] FAIL b2b_hold got v=%b s=%h o=%b exp 1/7/0", evt_valid, evt_state, evt_overrun); end
        @(negedge sys_clk);
        evt_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_accept got v=%b exp 0", evt_valid); end
    endtask

`ifdef JTAG_GLITCH_FILTER_EN
    task automatic test_glitch_filter();
        int rises;
        int first;
        do_reset();
        evt_ready = 1'b1;
        rises = 0;
        @(negedge sys_clk);
        jtag_clk = 1'b1;
        repeat (3) @(negedge sys_clk);
        jtag_clk = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(posedge sys_clk);
            #1;
            if (tck_rise === 1'b1) rises++;
        end
        checks++; if (rises !== 0 || tap_state !== 4'hF) begin failures++; $display("[TB] FAIL glitch_3cyc got rises=%0d state=%h exp 0/F", rises, tap_state); end
        rises = 0;
        first = -1;
        @(negedge sys_clk);
        jtag_tms = 1'b0;
        repeat (8) @(negedge sys_clk);
        for (int k = 0; k < 20; k++) begin
            jtag_clk = (k < 6);
            @(posedge sys_clk);
            #1;
            if (tck_rise === 1'b1) begin
                rises++;
                if (first < 0) first = k;
            end
            @(negedge sys_clk);
        end
        checks++; if (rises !== 1 || first !== 6) begin failures++; $display("[TB] FAIL pulse_6cyc got rises=%0d edge=%0d exp 1 at 6", rises, first); end
        checks++; if (tap_state !== 4'hC) begin failures++; $display("[TB] FAIL pulse_6cyc_state got=%h exp=C", tap_state); end
    endtask
`endif

    task automatic test_async_reset();
        logic       tms_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int         bad;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tck_pulse(tms_seq[i], 99, p_rises, p_edge, p_valid, p_state);
        end
        checks++; if (tap_state !== 4'h2 || evt_valid !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre got state=%h v=%b exp 2/1", tap_state, evt_valid); end
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        checks++; if (tap_state !== 4'hF || test_logic_reset !== 1'b1 || evt_state !== 4'hF) begin failures++; $display("[TB] FAIL arst_immediate got state=%h tlr=%b evt=%h exp F/1/F", tap_state, test_logic_reset, evt_state); end
        checks++; if (evt_valid !== 1'b0 || evt_overrun !== 1'b0 || tck_rise !== 1'b0) begin failures++; $display("[TB] FAIL arst_flags got v=%b o=%b r=%b exp 0/0/0", evt_valid, evt_overrun, tck_rise); end
        jtag_tms = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge sys_clk);
            #1;
            if (evt_valid !== 1'b0 || tap_state !== 4'hF) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL arst_quiet got bad_cycles=%0d exp 0", bad); end
        tck_pulse(1'b1, -1, p_rises, p_edge, p_valid, p_state);
        checks++; if (p_rises !== 1 || p_edge !== LAT || evt_valid !== 1'b0 || tap_state !== 4'hF) begin failures++; $display("[TB] FAIL arst_tlr_loop got rises=%0d edge=%0d v=%b state=%h exp 1/%0d/0/F", p_rises, p_edge, evt_valid, tap_state, LAT); end
    endtask

    initial begin
        $display("[TB] starting jtag_tap_tracker bench, latency %0d", LAT);
        test_reset();
        test_walk_to_shdr();
        test_ir_to_tlr();
        test_overrun();
        test_back_to_back();
`ifdef JTAG_GLITCH_FILTER_EN
        test_glitch_filter();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
